// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the ALUR/ALUI/CMPR/CMPI subset.
// Owns PC, IR and retired counter; illegal instructions and fetch timeouts latch a sticky fault.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef FUNC_BITS
`define FUNC_BITS 4
`endif
`ifndef ALUIN2_REG
`define ALUIN2_REG 1'b0
`define ALUIN2_IMM 1'b1
`endif
`ifndef OPCODE_ALUR
`define OPCODE_ALUR 4'b1100
`define OPCODE_ALUI 4'b0100
`define OPCODE_CMPR 4'b1101
`define OPCODE_CMPI 4'b0101
`endif
`ifndef INSTR_ADD
`define INSTR_ADD  5'b0_0000
`define INSTR_SUB  5'b0_0001
`define INSTR_AND  5'b0_0100
`define INSTR_OR   5'b0_0101
`define INSTR_XOR  5'b0_0110
`define INSTR_NAND 5'b0_1100
`define INSTR_NOR  5'b0_1101
`define INSTR_XNOR 5'b0_1110
`define INSTR_MVHI 5'b0_1011
`define INSTR_F    5'b1_0000
`define INSTR_EQ   5'b1_0001
`define INSTR_LT   5'b1_0010
`define INSTR_LTE  5'b1_0011
`define INSTR_T    5'b1_1000
`define INSTR_NE   5'b1_1001
`define INSTR_GTE  5'b1_1010
`define INSTR_GT   5'b1_1011
`endif

module instr_sequencer #(
  parameter int unsigned                WORD_SIZE    = `WORD_SIZE,
  parameter logic [`WORD_SIZE-1:0]      RESET_PC     = 32'h0000_0000,
  parameter int unsigned                IMEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  halt_req,
  output logic                  imem_req,
  output logic [WORD_SIZE-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_SIZE-1:0]  imem_rdata,
  output logic [`FUNC_BITS:0]   alu_func,
  output logic                  alu_in2_mux,
  output logic [3:0]            regno1,
  output logic [3:0]            regno2,
  output logic [WORD_SIZE-1:0]  imm_out,
  output logic                  regfile_wrtEn,
  output logic [3:0]            regfile_wrtRegno,
  output logic [WORD_SIZE-1:0]  pc,
  output logic [WORD_SIZE-1:0]  retired,
  output logic                  busy,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam int TW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FAULT
  } state_t;

  state_t state, state_next;

  logic [WORD_SIZE-1:0]  ir;
  logic [TW-1:0]         tout_cnt;
  logic [3:0]            fn;
  logic [3:0]            opcode;
  logic [`FUNC_BITS:0]   dec_func;
  logic                  dec_legal;
  logic                  dec_imm;

  assign fn               = ir[31:28];
  assign opcode           = ir[27:24];
  assign regno1           = ir[7:4];
  assign regno2           = ir[11:8];
  assign regfile_wrtRegno = ir[3:0];
  assign imm_out          = {{(WORD_SIZE-16){ir[23]}}, ir[23:8]};
  assign imem_addr        = pc;

  // The MSB of the ALU function code distinguishes compare from arithmetic classes.
  always_comb begin
    dec_func  = '0;
    dec_legal = 1'b0;
    dec_imm   = 1'b0;
    case (opcode)
      `OPCODE_ALUR, `OPCODE_ALUI: begin
        dec_imm  = (opcode == `OPCODE_ALUI);
        dec_func = {1'b0, fn};
        case ({1'b0, fn})
          `INSTR_ADD, `INSTR_SUB, `INSTR_AND, `INSTR_OR, `INSTR_XOR,
          `INSTR_NAND, `INSTR_NOR, `INSTR_XNOR, `INSTR_MVHI: dec_legal = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      `OPCODE_CMPR, `OPCODE_CMPI: begin
        dec_imm  = (opcode == `OPCODE_CMPI);
        dec_func = {1'b1, fn};
        case ({1'b1, fn})
          `INSTR_F, `INSTR_EQ, `INSTR_LT, `INSTR_LTE,
          `INSTR_T, `INSTR_NE, `INSTR_GTE, `INSTR_GT: dec_legal = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // An ack in the final allowed FETCH cycle still wins over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = FETCH;
      FETCH: begin
        if (imem_ack)                   state_next = DECODE;
        else if (tout_cnt == TOUT_LAST) state_next = FAULT;
      end
      DECODE:    state_next = dec_legal ? EXECUTE : FAULT;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = halt_req ? IDLE : FETCH;
      FAULT:     state_next = FAULT;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req      = (state == FETCH);
    regfile_wrtEn = (state == WRITEBACK);
    busy          = (state != IDLE) && (state != FAULT);
    fault         = (state == FAULT);
    alu_func      = '0;
    alu_in2_mux   = `ALUIN2_REG;
    if (state == DECODE || state == EXECUTE || state == WRITEBACK) begin
      alu_func    = dec_func;
      alu_in2_mux = dec_imm ? `ALUIN2_IMM : `ALUIN2_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      ir         <= '0;
      retired    <= '0;
      tout_cnt   <= '0;
      fault_code <= 2'b00;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            tout_cnt <= '0;
          end else begin
            tout_cnt <= tout_cnt + TW'(1);
            if (tout_cnt == TOUT_LAST) fault_code <= 2'b01;
          end
        end
        DECODE: if (!dec_legal) fault_code <= 2'b10;
        WRITEBACK: begin
          pc      <= pc + WORD_SIZE'(4);
          retired <= retired + WORD_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: retirement timing, decode outputs, halt, reset,
// fetch timeout and illegal-instruction faults, checked against hand-computed values.

module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  alu_func;
  logic        alu_in2_mux;
  logic [3:0]  regno1;
  logic [3:0]  regno2;
  logic [31:0] imm_out;
  logic        regfile_wrtEn;
  logic [3:0]  regfile_wrtRegno;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] I_ADD    = 32'h0C00_0321;
  localparam logic [31:0] I_SUBI   = 32'h1480_0105;
  localparam logic [31:0] I_CMPREQ = 32'h1D00_0037;
  localparam logic [31:0] I_BADCMP = 32'h4D00_0021;

  instr_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .alu_func(alu_func), .alu_in2_mux(alu_in2_mux),
    .regno1(regno1), .regno2(regno2), .imm_out(imm_out),
    .regfile_wrtEn(regfile_wrtEn), .regfile_wrtRegno(regfile_wrtRegno),
    .pc(pc), .retired(retired), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);
    tick();
    check_output("rst_pc", pc, 32'h0);
    check_output("rst_retired", retired, 32'h0);
    check_output("rst_busy", {31'b0, busy}, 32'h0);
    check_output("rst_req", {31'b0, imem_req}, 32'h0);
    check_output("rst_fault_code", {30'b0, fault_code}, 32'h0);
    check_output("rst_imm", imm_out, 32'h0);
    reset_n = 1'b1;
    tick();

    // Three back-to-back ADDs with same-cycle ack; halt in the third writeback.
    imem_ack = 1'b1; imem_rdata = I_ADD; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_output("add_fetch_req", {31'b0, imem_req}, 32'h1);
      check_output("add_fetch_addr", imem_addr, 32'(4 * k));
      tick();
      check_output("add_dec_wen", {31'b0, regfile_wrtEn}, 32'h0);
      tick();
      check_output("add_exe_wen", {31'b0, regfile_wrtEn}, 32'h0);
      tick();
      check_output("add_wb_wen", {31'b0, regfile_wrtEn}, 32'h1);
      check_output("add_wb_rd", {28'b0, regfile_wrtRegno}, 32'h1);
      check_output("add_wb_rs", {24'b0, regno2, regno1}, 32'h32);
      check_output("add_wb_pc", pc, 32'(4 * k));
      halt_req = (k == 2);
      tick();
      halt_req = 1'b0;
    end
    check_output("add_pc_end", pc, 32'd12);
    check_output("add_retired", retired, 32'd3);
    check_output("add_idle", {31'b0, busy}, 32'h0);

    // ALUI SUB with a negative immediate.
    imem_rdata = I_SUBI; start = 1'b1;
    tick();
    start = 1'b0;
    check_output("subi_addr", imem_addr, 32'd12);
    tick();
    check_output("subi_func", {27'b0, alu_func}, 32'h01);
    check_output("subi_mux", {31'b0, alu_in2_mux}, 32'h1);
    check_output("subi_imm", imm_out, 32'hFFFF_8001);
    tick();
    tick();
    check_output("subi_rd", {28'b0, regfile_wrtRegno}, 32'h5);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_output("subi_pc", pc, 32'd16);
    check_output("subi_idle_func", {27'b0, alu_func}, 32'h0);
    check_output("subi_idle_mux", {31'b0, alu_in2_mux}, 32'h0);

    // Halt during the second writeback, then resume and reset mid-execute.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    imem_rdata = I_ADD; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tick();
    imem_rdata = I_CMPREQ;
    tick();
    tick();
    check_output("cmpr_func", {27'b0, alu_func}, 32'h11);
    check_output("cmpr_mux", {31'b0, alu_in2_mux}, 32'h0);
    tick();
    check_output("cmpr_wb_rd", {28'b0, regfile_wrtRegno}, 32'h7);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_output("halt_pc", pc, 32'd8);
    check_output("halt_busy", {31'b0, busy}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("resume_addr", imem_addr, 32'd8);
    tick(); tick();
    check_output("exe_busy", {31'b0, busy}, 32'h1);
    reset_n = 1'b0;
    tick();
    check_output("midrst_busy", {31'b0, busy}, 32'h0);
    check_output("midrst_pc", pc, 32'h0);
    check_output("midrst_retired", retired, 32'h0);
    check_output("midrst_wen", {31'b0, regfile_wrtEn}, 32'h0);
    check_output("midrst_rd", {28'b0, regfile_wrtRegno}, 32'h0);
    reset_n = 1'b1;

    // 16 FETCH cycles with no ack.
    imem_ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check_output("tout_still_fetch", {31'b0, imem_req}, 32'h1);
    check_output("tout_no_fault_yet", {31'b0, fault}, 32'h0);
    tick();
    check_output("tout_fault", {31'b0, fault}, 32'h1);
    check_output("tout_code", {30'b0, fault_code}, 32'h1);
    check_output("tout_req", {31'b0, imem_req}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("tout_sticky", {31'b0, fault}, 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_output("tout_cleared", {30'b0, fault_code}, 32'h0);

    // Ack arrives in the 16th FETCH cycle: no fault, retires after 19 cycles.
    imem_rdata = I_ADD; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check_output("late_ack_no_fault", {31'b0, fault}, 32'h0);
    tick();
    check_output("late_c18_wen", {31'b0, regfile_wrtEn}, 32'h0);
    tick();
    check_output("late_c19_wen", {31'b0, regfile_wrtEn}, 32'h1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_output("late_retired", retired, 32'd1);
    check_output("late_pc", pc, 32'd4);

    // Undefined compare function faults in DECODE.
    imem_ack = 1'b1; imem_rdata = I_BADCMP; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("bad_dec_busy", {31'b0, busy}, 32'h1);
    tick();
    check_output("bad_fault", {31'b0, fault}, 32'h1);
    check_output("bad_code", {30'b0, fault_code}, 32'h2);
    check_output("bad_wen", {31'b0, regfile_wrtEn}, 32'h0);
    check_output("bad_pc", pc, 32'd4);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check_output("bad_sticky", {31'b0, fault}, 32'h1);
    check_output("bad_retired", retired, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_output("final_fault", {31'b0, fault}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute and writeback for the ALU/compare subset of the ISA (`ALUR`, `ALUI`, `CMPR`, `CMPI`). It sits between the instruction memory port and the datapath: register file, ALU, immediate sign-extender and in2 mux. It owns the PC, the instruction register and a retired-instruction counter. It drives fully defined control outputs and never drives `z`. Unsupported opcodes and functions, and instruction-memory timeouts, put it into a sticky fault state.

## Interface
Parameters:
- `WORD_SIZE`, `` `WORD_SIZE `` (32): PC, instruction, immediate and counter width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `IMEM_TIMEOUT`, 16: maximum FETCH cycles without `imem_ack` before fault; must be ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching at the current PC.
- `halt_req`  in  1  stop after the current instruction retires.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  WORD_SIZE  fetch address; always equals `pc`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  WORD_SIZE  fetched instruction.
- `alu_func`  out  `` `FUNC_BITS+1 ``  ALU function code.
- `alu_in2_mux`  out  1  `` `ALUIN2_REG `` or `` `ALUIN2_IMM ``.
- `regno1`, `regno2`  out  4 each  source register numbers (IR[7:4], IR[11:8]).
- `imm_out`  out  WORD_SIZE  IR[23:8] sign-extended.
- `regfile_wrtEn`  out  1  register-file write strobe.
- `regfile_wrtRegno`  out  4  destination register (IR[3:0]).
- `pc`  out  WORD_SIZE  current PC.
- `retired`  out  WORD_SIZE  count of retired instructions.
- `busy`  out  1  high in every state except IDLE and FAULT.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  01 = fetch timeout, 10 = illegal instruction, 00 = none.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FAULT.
- **IDLE**: outputs quiescent. `start`=1 moves to FETCH.
- **FETCH**: `imem_req`=1.
  - On `imem_ack`, latch `imem_rdata` into IR, clear the timeout counter and move to DECODE.
  - Without ack, increment the timeout counter. When the count reaches `IMEM_TIMEOUT`, move to FAULT with code 01.
- **DECODE**: field split is fn = IR[31:28], opcode = IR[27:24].
  - The opcode must be one of the four supported opcodes.
  - The fn must map to a defined `` `INSTR_* `` for its class: ADD..MVHI for ALU opcodes, F..GT for CMP opcodes.
  - Otherwise move to FAULT with code 10. The IR is kept for debug.
  - Valid instruction moves to EXECUTE.
- **EXECUTE**: one cycle for operand read and combinational ALU settle. Moves to WRITEBACK.
- **WRITEBACK**: `regfile_wrtEn`=1 for exactly this cycle; `pc` += 4 (wraps modulo 2^WORD_SIZE); `retired` += 1 (wraps). Next state is IDLE if `halt_req`=1, else FETCH.
- **FAULT**: sticky. Only `reset_n`=0 exits. `start` is ignored.
- Decoded outputs are driven from IR, combinationally, in DECODE, EXECUTE and WRITEBACK:
  - `alu_func` follows the same fn mapping as the decode check.
  - `alu_in2_mux` is REG for `ALUR`/`CMPR` and IMM for `ALUI`/`CMPI`.
  - In all other states `alu_func`=0 and `alu_in2_mux`=0.
- `regno1`, `regno2`, `regfile_wrtRegno` and `imm_out` are always driven from IR.
- `start` is ignored while busy. `halt_req` is sampled only in WRITEBACK.

## Timing
- Reset (`reset_n`=0 at an edge) gives: state IDLE, `pc`=RESET_PC, IR=0, `retired`=0, timeout counter 0, `fault_code`=00. All outputs are 0 except `imem_addr`=`pc`=RESET_PC and the IR-derived outputs, which show 0.
- Reset mid-operation takes effect at the next edge: `imem_req` and `regfile_wrtEn` drop and no PC or counter update occurs.
- Minimum latency is 4 cycles per instruction (FETCH with same-cycle ack, DECODE, EXECUTE, WRITEBACK). Each cycle of ack delay adds one cycle.
- `imem_addr` is stable for the whole of FETCH. An `imem_ack` outside FETCH is ignored.
- An ack arriving in the same cycle the timeout count reaches its limit wins: the fetch succeeds and no fault is raised.
- `pc` and `retired` update on the edge that ends WRITEBACK. The register-file write uses pre-update IR fields.

## Test plan
- Reset, then `start`; `imem_ack`=1 every cycle; 3× `ALUR` ADD (rd=1, rs1=2, rs2=3) -> `regfile_wrtEn` pulses every 4th cycle with regno 1; `pc` goes 0,4,8,12; `retired`=3.
- `ALUI` SUB with imm 16'h8001 -> `alu_in2_mux`=IMM, `imm_out`=32'hFFFF_8001, `alu_func`=`` `SUB ``.
- `CMPR` with an undefined fn -> FAULT with `fault_code`=10, no write pulse, `pc` unchanged; `start` ignored until reset.
- Hold `imem_ack`=0 for 16 FETCH cycles -> FAULT with code 01. Repeat with ack on cycle 16 -> no fault, 19 total cycles to retire.
- `halt_req`=1 during the second WRITEBACK -> IDLE with `pc`=8; `start` then resumes fetching at 8.
- `reset_n`=0 during EXECUTE -> next cycle IDLE with `pc`=RESET_PC, `retired`=0, no write strobe.
